key_entry_controller: RTL

- Sequences the keypad scanner output (press level plus 4-bit key_value) into a complete charge-amount transaction: start, digit entry, clear, confirm.
- Hands a validated amount to the charge controller through a valid/ack handshake.
- Blocks further entry until the charge controller reports completion.
- Sits between the keypad scanner and the amount/charge control logic, in the same 1000 Hz clock domain.

---
 rtl/key_entry_controller_pkg.sv | 26 ++
 rtl/key_entry_controller_key_event_detect.sv | 28 ++
 rtl/key_entry_controller.sv | 118 +++++++++++
 3 files changed

// File: rtl/key_entry_controller_pkg.sv
// Shared constants for the key entry controller: key codes, state
// encoding and the clock rate used to size the entry timeout.
package key_entry_controller_pkg;

    // System clock after division, in Hz
    localparam int CLK_HZ      = 1000;
    // Seconds of keypad inactivity tolerated in ENTRY
    localparam int TIMEOUT_SEC = 10;

    // Command key codes from the scanner (0-9 are digits)
    localparam logic [3:0] KEY_START   = 4'd10;
    localparam logic [3:0] KEY_CLEAR   = 4'd11;
    localparam logic [3:0] KEY_CONFIRM = 4'd12;

    // State encoding, also exported on the state port for the display
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ENTRY    = 2'd1;
    localparam logic [1:0] ST_OFFER    = 2'd2;
    localparam logic [1:0] ST_CHARGING = 2'd3;

    // True for the decimal digit keys 0-9
    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/key_entry_controller_key_event_detect.sv
// Turns the scanner's held-key level into a single-cycle key event.
// The event and its code are combinational so the controller registers
// the key on the very edge that first sees press high, giving one cycle
// from press rising to the resulting state/amount change.
module key_event_detect (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       press,
    input  logic [3:0] key_value,
    output logic       evt,
    output logic [3:0] evt_code
);

    logic press_q;

    // Press history; cleared by reset so a key held across reset release still fires once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_q <= 1'b0;
        end else begin
            press_q <= press;
        end
    end

    assign evt      = press & ~press_q;
    assign evt_code = key_value;

endmodule

// File: rtl/key_entry_controller.sv
// Keypad transaction sequencer: start, digit entry, clear and confirm,
// then offers the amount to the charge controller and waits for it to
// finish before accepting a new entry.
module key_entry_controller
    import key_entry_controller_pkg::*;
#(
    parameter int MAX_DIGITS = 2,
    parameter int MAX_AMOUNT = 20,
    parameter int AMT_W      = 7,
    parameter int TIMEOUT    = TIMEOUT_SEC * CLK_HZ
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             press,
    input  logic [3:0]       key_value,
    input  logic             ack,
    input  logic             charge_done,
    output logic [AMT_W-1:0] amount,
    output logic [1:0]       digit_cnt,
    output logic             amount_valid,
    output logic             entry_active,
    output logic             err,
    output logic [1:0]       state
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic             evt;
    logic [3:0]       evt_code;
    logic [TMO_W-1:0] tmo_cnt;
    logic [AMT_W+3:0] amount_x10;

    key_event_detect u_evt (
        .clk       (clk),
        .rst_n     (rst_n),
        .press     (press),
        .key_value (key_value),
        .evt       (evt),
        .evt_code  (evt_code)
    );

    // Widened so amount*10+digit never wraps before truncation back to AMT_W
    assign amount_x10 = {4'b0000, amount} * (AMT_W + 4)'(10) + {{AMT_W{1'b0}}, evt_code};

    // Transaction FSM with its amount, digit count, error pulse and inactivity timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            amount    <= '0;
            digit_cnt <= '0;
            err       <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (evt && evt_code == KEY_START) begin
                        state     <= ST_ENTRY;
                        amount    <= '0;
                        digit_cnt <= '0;
                        tmo_cnt   <= '0;
                    end
                end
                ST_ENTRY: begin
                    if (evt) begin
                        tmo_cnt <= '0;
                        if (is_digit(evt_code)) begin
                            if (digit_cnt < 2'(MAX_DIGITS)) begin
                                amount    <= amount_x10[AMT_W-1:0];
                                digit_cnt <= digit_cnt + 2'd1;
                            end else begin
                                err <= 1'b1;
                            end
                        end else if (evt_code == KEY_CLEAR || evt_code == KEY_START) begin
                            amount    <= '0;
                            digit_cnt <= '0;
                        end else if (evt_code == KEY_CONFIRM) begin
                            if (digit_cnt == 2'd0 || amount == '0 || amount > AMT_W'(MAX_AMOUNT)) begin
                                err       <= 1'b1;
                                amount    <= '0;
                                digit_cnt <= '0;
                            end else begin
                                state <= ST_OFFER;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        state     <= ST_IDLE;
                        amount    <= '0;
                        digit_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_OFFER: begin
                    if (ack) begin
                        state <= ST_CHARGING;
                    end
                end
                ST_CHARGING: begin
                    if (charge_done) begin
                        state     <= ST_IDLE;
                        amount    <= '0;
                        digit_cnt <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign amount_valid = (state == ST_OFFER);
    assign entry_active = (state == ST_ENTRY);

endmodule
